// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV32M divide path: operation codes and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_m_pkg;

  // Operation codes, equal to funct3[1:0] of the RV32M divide instructions.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  // Divider sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Bit 0 clear selects the signed flavour (DIV/REM).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 set selects the remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration, purely combinational.
// Latency: 0 cycles. Backpressure: none (no handshake).
// Ports: rem_in/q_in/divisor -> rem_out/q_out. q_in holds the not-yet-consumed
// dividend bits in its upper part and the quotient bits collected so far below.
module div_step
  import rv_m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);

  // Partial remainder shifted left with the next dividend bit appended.
  // One extra bit on top so the subtraction's borrow lands in the MSB.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  assign shifted = {rem_in, q_in[WIDTH-1]};
  assign trial   = shifted - {2'b00, divisor};
  // The partial remainder is always below the divisor, so a borrow is the
  // only way the trial difference can have its top bit set.
  assign fits    = ~trial[WIDTH+1];

  always_comb begin
    rem_out = shifted[WIDTH:0];
    if (fits) begin
      rem_out = trial[WIDTH:0];
    end
  end

  assign q_out = {q_in[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: WIDTH+1 cycles from the accepting edge to done; 1 cycle for b=0 or signed overflow.
// Backpressure: start is only taken while busy=0; no queuing, flush kills the operation in flight.
// Ports: clk, rst_n, start/op/a/b (request), flush (kill), busy/done/result (status and answer).
module div_unit
  import rv_m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  op_t              op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful on the accepting edge)
  // ---------------------------------------------------------------------------
  logic             req_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_by_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_res;

  assign req_signed  = op_is_signed(op);
  assign a_neg       = req_signed & a[WIDTH-1];
  assign b_neg       = req_signed & b[WIDTH-1];
  // Two's complement of the most negative value is itself, which is the
  // correct unsigned magnitude, so no special handling is needed here.
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign div_by_zero = (b == '0);
  assign overflow    = req_signed && (a == MIN_NEG) && (b == ALL_ONES);

  always_comb begin
    special_res = '0;
    if (div_by_zero) begin
      special_res = op_is_rem(op) ? a : ALL_ONES;
    end else if (!op_is_rem(op)) begin
      special_res = MIN_NEG;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .q_in    (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // ---------------------------------------------------------------------------
  // Sign correction of the finished magnitudes
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

  assign rem_mag = rem_q[WIDTH-1:0];
  // sign_a/sign_b are only ever set for signed ops, so no op check here.
  assign fin_quo = (sign_a ^ sign_b) ? -quo_q : quo_q;
  assign fin_rem = sign_a ? -rem_mag : rem_mag;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_DIV;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Kill wins over a new request and over completion; result is kept.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (div_by_zero || overflow) begin
                // Answer known up front: stay idle and report next cycle.
                result <= special_res;
                done   <= 1'b1;
              end else begin
                op_q   <= op_t'(op);
                sign_a <= a_neg;
                sign_b <= b_neg;
                quo_q  <= a_mag;
                div_q  <= b_mag;
                rem_q  <= '0;
                cnt    <= '0;
                state  <= RUN;
              end
            end
          end
          RUN: begin
            rem_q <= step_rem;
            quo_q <= step_q;
            if (cnt == CNT_LAST) begin
              state <= FIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FIN: begin
            result <= op_is_rem(op_q) ? fin_rem : fin_quo;
            done   <= 1'b1;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_div_unit;
  import rv_m_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model straight from the RV32M rules.
  function automatic logic [W-1:0] model_res(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx;
    logic signed [W-1:0] sy;
    sx = x;
    sy = y;
    if (y == 0) return o[1] ? x : '1;
    if (!o[0] && x == MIN_V && y == '1) return o[1] ? '0 : MIN_V;
    case (o)
      2'b00:   return sx / sy;
      2'b01:   return x / y;
      2'b10:   return sx % sy;
      default: return x % y;
    endcase
  endfunction

  function automatic bit model_special(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == 0) || (!o[0] && x == MIN_V && y == '1);
  endfunction

  // Called at a negedge; drives a one-cycle start and predicts acceptance.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string nm);
    exp_t e;
    bit   acc;
    acc   = !busy && !flush && rst_n;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (acc) begin
      e.res  = model_res(o, x, y);
      e.due  = cyc + 1 + (model_special(o, x, y) ? 0 : W + 1);
      e.name = nm;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_bound", 32'(busy), 32'(0));
  endtask

  // Monitor: pops the scoreboard whenever done is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        check({e.name, "_missing_done"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] prior;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    rst_n = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_result", result, 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Signed division of a negative dividend.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    wait_idle();
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    wait_idle();

    // Unsigned, with busy duration measured.
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, "divu_max_16");
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("divu_busy_cycles", 32'(n), 32'(W + 1));
    issue(OP_REMU, 32'hFFFF_FFFF, 32'h10, "remu_max_16");
    wait_idle();

    // Divide by zero, back to back (consecutive done pulses).
    issue(OP_DIVU, 32'd5, 32'd0, "divu_5_0");
    issue(OP_REMU, 32'd5, 32'd0, "remu_5_0");
    issue(OP_DIV, 32'hFFFF_FFEC, 32'd0, "div_m20_0");
    issue(OP_REM, 32'hFFFF_FFEC, 32'd0, "rem_m20_0");
    // Signed overflow.
    issue(OP_DIV, MIN_V, 32'hFFFF_FFFF, "div_ovf");
    issue(OP_REM, MIN_V, 32'hFFFF_FFFF, "rem_ovf");
    repeat (2) @(negedge clk);

    // Flush during iteration: no done, result unchanged.
    prior = result;
    issue(OP_DIVU, 32'd100, 32'd7, "flushed");
    repeat (10) @(negedge clk);
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'(0));
    check("flush_result_kept", result, prior);
    repeat (40) @(negedge clk);
    check("flush_result_still_kept", result, prior);

    // Flush while idle drops a coincident start (even a special case).
    flush = 1'b1;
    issue(OP_DIVU, 32'd5, 32'd0, "dropped");
    flush = 1'b0;
    check("idle_flush_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);

    // Start while busy is ignored.
    issue(OP_DIVU, 32'd1000, 32'd10, "busy_a");
    repeat (5) @(negedge clk);
    issue(OP_DIV, 32'd7, 32'd0, "ignored");
    wait_idle();
    repeat (2) @(negedge clk);

    // Start in the done cycle.
    issue(OP_DIV, 32'd100, 32'hFFFF_FFFD, "b2b_1");
    wait_idle();
    check("b2b_done_cycle", 32'(done), 32'(1));
    issue(OP_REMU, 32'd12345, 32'd67, "b2b_2");
    wait_idle();
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-operation.
    issue(OP_DIV, 32'd1000, 32'd3, "reset_victim");
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_busy", 32'(busy), 32'(0));
    check("midreset_done", 32'(done), 32'(0));
    check("midreset_result", result, 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_DIV, 32'd42, 32'hFFFF_FFFA, "div_42_m6");
    wait_idle();

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = MIN_V;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        4:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, "rand");
      if ($urandom_range(0, 3) == 0 && busy) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        issue(OP_DIVU, $urandom, $urandom, "rand_ignored");
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
